// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch sequencer: top-level and per-channel state
// encodings, configuration field addresses and ctrl register bit positions.
package glitch_pkg;

  // Sequencer state, visible on o_state.
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StArmed    = 2'd1,
    StRunning  = 2'd2,
    StCooldown = 2'd3
  } seq_state_e;

  // Per-channel pulse generator state.
  typedef enum logic [1:0] {
    ChWait = 2'd0,
    ChFire = 2'd1,
    ChGap  = 2'd2,
    ChDone = 2'd3
  } ch_state_e;

  // Field select in i_cfg_addr[3:0].
  localparam logic [3:0] FieldDelay  = 4'd0;
  localparam logic [3:0] FieldWidth  = 4'd1;
  localparam logic [3:0] FieldRepeat = 4'd2;
  localparam logic [3:0] FieldGap    = 4'd3;
  localparam logic [3:0] FieldCtrl   = 4'd4;

  // Ctrl register bits. Polarity is only honoured on channel 0.
  localparam int unsigned CtrlEnBit  = 0;
  localparam int unsigned CtrlPolBit = 1;

endpackage

// File: rtl/glitch_channel.sv
// One glitch output channel: waits delay cycles after start, fires width+1
// cycles high, then repeats with gap+1 low cycles until repeat+1 pulses have
// fired. Idles in ChDone between runs.
module glitch_channel
  import glitch_pkg::*;
#(
  parameter int unsigned CW = 32,
  parameter int unsigned RW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] delay_i,
  input  logic [CW-1:0] width_i,
  input  logic [CW-1:0] gap_i,
  input  logic [RW-1:0] rep_i,
  output logic          glitch_o,
  output logic          done_o
);

  ch_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] pcnt_q;  // pulses completed before the current one
  logic          glitch_q;

  // Channel FSM; glitch output is registered so it lines up with the
  // sequencer's first RUNNING cycle when delay is zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ChDone;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      glitch_q <= 1'b0;
    end else if (clr_i) begin
      state_q  <= ChDone;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      glitch_q <= 1'b0;
    end else if (start_i) begin
      cnt_q  <= '0;
      pcnt_q <= '0;
      if (!en_i) begin
        state_q  <= ChDone;
        glitch_q <= 1'b0;
      end else if (delay_i == '0) begin
        state_q  <= ChFire;
        glitch_q <= 1'b1;
      end else begin
        state_q  <= ChWait;
        glitch_q <= 1'b0;
      end
    end else begin
      unique case (state_q)
        ChWait: begin
          // delay_i is non-zero here, so the subtraction cannot wrap
          if (cnt_q == delay_i - CW'(1)) begin
            state_q  <= ChFire;
            glitch_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ChFire: begin
          if (cnt_q == width_i) begin
            glitch_q <= 1'b0;
            cnt_q    <= '0;
            if (pcnt_q < rep_i) begin
              pcnt_q  <= pcnt_q + RW'(1);
              state_q <= ChGap;
            end else begin
              state_q <= ChDone;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ChGap: begin
          if (cnt_q == gap_i) begin
            state_q  <= ChFire;
            glitch_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ChDone: begin
          glitch_q <= 1'b0;
        end
      endcase
    end
  end

  assign glitch_o = glitch_q;
  assign done_o   = (state_q == ChDone);

endmodule

// File: rtl/glitch_sequencer.sv
// Multi-channel glitch sequencer. Arm, then an external trigger edge or a
// manual pulse starts all enabled channels together; o_done pulses once all
// channels have finished. Optional macro GLITCH_TRIG_FILTER_EN adds a FILT-cycle
// stability filter on the synchronised trigger.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int unsigned CH   = 4,
  parameter int unsigned CW   = 32,
  parameter int unsigned RW   = 16,
  parameter int unsigned FILT = 4
) (
  input  logic          sysclk,
  input  logic          rst_n,
  input  logic          i_cfg_we,
  input  logic [7:0]    i_cfg_addr,
  input  logic [CW-1:0] i_cfg_wdata,
  input  logic          i_arm,
  input  logic          i_disarm,
  input  logic          i_manual,
  input  logic          i_trig,
  output logic [CH-1:0] o_glitch,
  output logic [1:0]    o_state,
  output logic          o_done,
  output logic          o_cfg_err
);

  if (CH < 1 || CH > 16 || CW < 2 || RW > CW || FILT < 1) begin : g_param_check
    $error("glitch_sequencer: unsupported parameter combination");
  end

  seq_state_e    state_q;
  logic          done_q;
  logic          cfg_err_q;
  logic          pol_q;
  logic          trig_s1_q, trig_s2_q, trig_prev_q;
  logic          trig_lvl;
  logic          trig_edge;
  logic          start;
  logic          all_done;
  logic [CH-1:0] done_vec;
  logic [3:0]    cfg_ch;
  logic [3:0]    cfg_field;
  logic          cfg_ok;
  logic          cfg_wr;

  assign cfg_ch    = i_cfg_addr[7:4];
  assign cfg_field = i_cfg_addr[3:0];
  assign cfg_ok    = (state_q == StIdle) && ({1'b0, cfg_ch} < 5'(CH)) &&
                     (cfg_field <= FieldCtrl);
  assign cfg_wr    = i_cfg_we && cfg_ok;

  // Two-flop synchroniser plus a delayed copy of the (filtered) level.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1_q   <= 1'b0;
      trig_s2_q   <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_s1_q   <= i_trig;
      trig_s2_q   <= trig_s1_q;
      trig_prev_q <= trig_lvl;
    end
  end

`ifdef GLITCH_TRIG_FILTER_EN
  localparam int unsigned FcW = $clog2(FILT + 1);

  logic [FcW-1:0] filt_cnt_q;
  logic           filt_lvl_q;

  // Follow the synchronised level only after it has differed for FILT cycles.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt_q <= '0;
      filt_lvl_q <= 1'b0;
    end else if (trig_s2_q == filt_lvl_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FcW'(FILT - 1)) begin
      filt_cnt_q <= '0;
      filt_lvl_q <= trig_s2_q;
    end else begin
      filt_cnt_q <= filt_cnt_q + FcW'(1);
    end
  end

  assign trig_lvl = filt_lvl_q;
`else
  assign trig_lvl = trig_s2_q;
`endif

  assign trig_edge = pol_q ? (trig_prev_q && !trig_lvl) : (!trig_prev_q && trig_lvl);

  // Channels launch on the same edge the sequencer enters RUNNING.
  assign start    = (state_q == StArmed) && (trig_edge || i_manual) && !i_disarm;
  assign all_done = &done_vec;

  // Top-level sequencer FSM with registered done pulse; disarm has priority.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_disarm) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle:     if (i_arm) state_q <= StArmed;
          StArmed:    if (trig_edge || i_manual) state_q <= StRunning;
          StRunning: begin
            if (all_done) begin
              state_q <= StCooldown;
              done_q  <= 1'b1;
            end
          end
          StCooldown: state_q <= StIdle;
          default:    state_q <= StIdle;
        endcase
      end
    end
  end

  // Rejected writes report one cycle later; trigger polarity lives in ch0 ctrl.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
      pol_q     <= 1'b0;
    end else begin
      cfg_err_q <= i_cfg_we && !cfg_ok;
      if (cfg_wr && cfg_ch == 4'd0 && cfg_field == FieldCtrl) begin
        pol_q <= i_cfg_wdata[CtrlPolBit];
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [CW-1:0] delay_q, width_q, gap_q;
    logic [RW-1:0] rep_q;
    logic          en_q;
    logic          glitch;

    // Per-channel configuration registers, writable only while idle.
    always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
        delay_q <= '0;
        width_q <= '0;
        gap_q   <= '0;
        rep_q   <= '0;
        en_q    <= 1'b0;
      end else if (cfg_wr && cfg_ch == 4'(c)) begin
        case (cfg_field)
          FieldDelay:  delay_q <= i_cfg_wdata;
          FieldWidth:  width_q <= i_cfg_wdata;
          FieldRepeat: rep_q   <= i_cfg_wdata[RW-1:0];
          FieldGap:    gap_q   <= i_cfg_wdata;
          FieldCtrl:   en_q    <= i_cfg_wdata[CtrlEnBit];
          default:     ;
        endcase
      end
    end

    glitch_channel #(
      .CW (CW),
      .RW (RW)
    ) u_chan (
      .clk_i    (sysclk),
      .rst_ni   (rst_n),
      .start_i  (start),
      .clr_i    (i_disarm),
      .en_i     (en_q),
      .delay_i  (delay_q),
      .width_i  (width_q),
      .gap_i    (gap_q),
      .rep_i    (rep_q),
      .glitch_o (glitch),
      .done_o   (done_vec[c])
    );

    assign o_glitch[c] = glitch;
  end

  assign o_state   = state_q;
  assign o_done    = done_q;
  assign o_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed plus randomized bench for glitch_sequencer. Expected pulse trains
// come from a closed-form model of each channel's schedule.
module tb_glitch_sequencer;

  localparam int CH   = 4;
  localparam int CW   = 32;
  localparam int RW   = 16;
  localparam int FILT = 4;
`ifdef GLITCH_TRIG_FILTER_EN
  localparam int TrigLat = 3 + FILT;
`else
  localparam int TrigLat = 3;
`endif

  logic          sysclk = 1'b0;
  logic          rst_n;
  logic          i_cfg_we;
  logic [7:0]    i_cfg_addr;
  logic [CW-1:0] i_cfg_wdata;
  logic          i_arm, i_disarm, i_manual, i_trig;
  logic [CH-1:0] o_glitch;
  logic [1:0]    o_state;
  logic          o_done, o_cfg_err;

  int checks = 0;
  int errors = 0;

  // Model of the configuration as seen by the bench.
  int m_delay[CH];
  int m_width[CH];
  int m_rep[CH];
  int m_gap[CH];
  bit m_en[CH];
  bit m_pol;

  always #5 sysclk = ~sysclk;

  glitch_sequencer #(
    .CH   (CH),
    .CW   (CW),
    .RW   (RW),
    .FILT (FILT)
  ) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .i_cfg_we    (i_cfg_we),
    .i_cfg_addr  (i_cfg_addr),
    .i_cfg_wdata (i_cfg_wdata),
    .i_arm       (i_arm),
    .i_disarm    (i_disarm),
    .i_manual    (i_manual),
    .i_trig      (i_trig),
    .o_glitch    (o_glitch),
    .o_state     (o_state),
    .o_done      (o_done),
    .o_cfg_err   (o_cfg_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      m_delay[c] = 0; m_width[c] = 0; m_rep[c] = 0; m_gap[c] = 0; m_en[c] = 0;
    end
    m_pol = 0;
  endtask

  // Channel c is high at RUNNING cycle idx if idx lands inside one of its pulses.
  function automatic bit exp_glitch(int c, int idx);
    int period, r;
    if (!m_en[c] || idx < m_delay[c]) return 1'b0;
    period = m_width[c] + m_gap[c] + 2;
    r = idx - m_delay[c];
    if (r / period > m_rep[c]) return 1'b0;
    return (r % period) <= m_width[c];
  endfunction

  function automatic logic [CH-1:0] exp_vec(int idx);
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = exp_glitch(c, idx);
    return v;
  endfunction

  // Index of the first RUNNING cycle in which every channel has finished.
  function automatic int run_end();
    int e = 0;
    int t;
    for (int c = 0; c < CH; c++) begin
      if (m_en[c]) begin
        t = m_delay[c] + (m_rep[c] + 1) * (m_width[c] + 1) + m_rep[c] * (m_gap[c] + 1);
        if (t > e) e = t;
      end
    end
    return e;
  endfunction

  task automatic model_apply(input int c, input int f, input logic [CW-1:0] d);
    case (f)
      0: m_delay[c] = int'(d);
      1: m_width[c] = int'(d);
      2: m_rep[c]   = int'(d[RW-1:0]);
      3: m_gap[c]   = int'(d);
      4: begin
        m_en[c] = d[0];
        if (c == 0) m_pol = d[1];
      end
      default: ;
    endcase
  endtask

  task automatic cfg_write(input int c, input int f, input logic [CW-1:0] d, input bit in_idle);
    bit bad;
    i_cfg_we    = 1'b1;
    i_cfg_addr  = 8'((c << 4) | f);
    i_cfg_wdata = d;
    tick();
    i_cfg_we = 1'b0;
    bad = !in_idle || c >= CH || f > 4;
    chk($sformatf("cfg_err c%0d f%0d", c, f), 64'(o_cfg_err), 64'(bad));
    if (bad) begin
      tick();
      chk("cfg_err_single", 64'(o_cfg_err), 64'(0));
    end else begin
      model_apply(c, f, d);
    end
  endtask

  task automatic prep_trig();
    i_trig = m_pol;
    repeat (10) tick();
  endtask

  task automatic do_arm();
    i_arm = 1'b1;
    tick();
    i_arm = 1'b0;
    chk("armed", 64'(o_state), 64'(1));
  endtask

  task automatic start_manual();
    i_manual = 1'b1;
    tick();
    i_manual = 1'b0;
  endtask

  task automatic start_trig();
    i_trig = !m_pol;
    for (int i = 1; i < TrigLat; i++) begin
      tick();
      chk($sformatf("trig_wait%0d", i), 64'(o_state), 64'(1));
    end
    tick();
  endtask

  // Called in the first RUNNING cycle; follows the run through to IDLE.
  task automatic check_run();
    int e = run_end();
    for (int idx = 0; idx <= e; idx++) begin
      chk($sformatf("run_state@%0d", idx), 64'(o_state), 64'(2));
      chk($sformatf("run_done@%0d", idx), 64'(o_done), 64'(0));
      chk($sformatf("glitch@%0d", idx), 64'(o_glitch), 64'(exp_vec(idx)));
      tick();
    end
    chk("cool_state", 64'(o_state), 64'(3));
    chk("cool_done", 64'(o_done), 64'(1));
    chk("cool_glitch", 64'(o_glitch), 64'(0));
    tick();
    chk("end_state", 64'(o_state), 64'(0));
    chk("end_done", 64'(o_done), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_wdata = '0;
    i_arm = 1'b0; i_disarm = 1'b0; i_manual = 1'b0; i_trig = 1'b0;
    model_clear();
    #23;
    chk("rst_state", 64'(o_state), 64'(0));
    chk("rst_glitch", 64'(o_glitch), 64'(0));
    chk("rst_done", 64'(o_done), 64'(0));
    chk("rst_cfg_err", 64'(o_cfg_err), 64'(0));
    @(negedge sysclk);
    rst_n = 1'b1;
    tick();

    // Disarm beats arm; manual outside ARMED is ignored.
    i_arm = 1'b1; i_disarm = 1'b1;
    tick();
    i_arm = 1'b0; i_disarm = 1'b0;
    chk("disarm_beats_arm", 64'(o_state), 64'(0));
    i_manual = 1'b1;
    tick();
    i_manual = 1'b0;
    chk("manual_idle", 64'(o_state), 64'(0));

    // Single pulse on ch0 from a rising trigger.
    cfg_write(0, 0, 10, 1);
    cfg_write(0, 1, 2, 1);
    cfg_write(0, 2, 0, 1);
    cfg_write(0, 4, 1, 1);
    prep_trig();
    do_arm();
    start_trig();
    check_run();

    // Repeated one-cycle pulses on ch1 from a manual start.
    cfg_write(0, 4, 0, 1);
    cfg_write(1, 0, 0, 1);
    cfg_write(1, 1, 0, 1);
    cfg_write(1, 2, 2, 1);
    cfg_write(1, 3, 4, 1);
    cfg_write(1, 4, 1, 1);
    do_arm();
    start_manual();
    check_run();

    // Illegal writes: out-of-range channel, bad field, and while ARMED.
    cfg_write(5, 0, 123, 1);
    cfg_write(1, 7, 5, 1);
    do_arm();
    cfg_write(1, 0, 7, 0);
    chk("armed_after_bad_write", 64'(o_state), 64'(1));
    start_manual();
    check_run();

    // Enable written in the same cycle as arm takes effect for this run.
    cfg_write(1, 4, 0, 1);
    cfg_write(2, 0, 3, 1);
    cfg_write(2, 1, 1, 1);
    i_cfg_we = 1'b1; i_cfg_addr = 8'h24; i_cfg_wdata = 1; i_arm = 1'b1;
    tick();
    i_cfg_we = 1'b0; i_arm = 1'b0;
    model_apply(2, 4, 1);
    chk("arm_with_write_state", 64'(o_state), 64'(1));
    chk("arm_with_write_err", 64'(o_cfg_err), 64'(0));
    start_manual();
    check_run();

    // Disarm while ch0 is mid-pulse.
    cfg_write(2, 4, 0, 1);
    cfg_write(0, 0, 3, 1);
    cfg_write(0, 1, 5, 1);
    cfg_write(0, 4, 1, 1);
    do_arm();
    start_manual();
    for (int idx = 0; idx < 4; idx++) begin
      chk($sformatf("pre_disarm@%0d", idx), 64'(o_glitch), 64'(exp_vec(idx)));
      tick();
    end
    chk("fire_before_disarm", 64'(o_glitch), 64'(exp_vec(4)));
    i_disarm = 1'b1; i_arm = 1'b1; i_manual = 1'b1;
    tick();
    i_disarm = 1'b0; i_arm = 1'b0; i_manual = 1'b0;
    chk("disarm_glitch", 64'(o_glitch), 64'(0));
    chk("disarm_state", 64'(o_state), 64'(0));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_disarm_done", 64'(o_done), 64'(0));
      chk("post_disarm_glitch", 64'(o_glitch), 64'(0));
    end
    do_arm();
    i_disarm = 1'b1; i_manual = 1'b1;
    tick();
    i_disarm = 1'b0; i_manual = 1'b0;
    chk("disarm_from_armed", 64'(o_state), 64'(0));

    // Randomized configurations and start sources.
    for (int n = 0; n < 8; n++) begin
      for (int c = 0; c < CH; c++) begin
        cfg_write(c, 0, CW'($urandom_range(0, 12)), 1);
        cfg_write(c, 1, CW'($urandom_range(0, 4)), 1);
        cfg_write(c, 2, CW'($urandom_range(0, 3)), 1);
        cfg_write(c, 3, CW'($urandom_range(0, 5)), 1);
        cfg_write(c, 4, CW'({$urandom_range(0, 1), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0}), 1);
      end
      prep_trig();
      do_arm();
      if ($urandom_range(0, 1) == 1) start_trig();
      else start_manual();
      check_run();
    end

`ifdef GLITCH_TRIG_FILTER_EN
    // Short trigger glitch is filtered, a long one triggers.
    for (int c = 1; c < CH; c++) cfg_write(c, 4, 0, 1);
    cfg_write(0, 0, 0, 1);
    cfg_write(0, 1, 0, 1);
    cfg_write(0, 2, 0, 1);
    cfg_write(0, 4, 1, 1);
    prep_trig();
    do_arm();
    i_trig = 1'b1;
    repeat (2) tick();
    i_trig = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("filt_short", 64'(o_state), 64'(1));
    end
    i_trig = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("filt_long_wait", 64'(o_state), 64'(1));
    end
    i_trig = 1'b0;
    tick();
    check_run();
`endif

    // Asynchronous reset in the middle of a pulse.
    cfg_write(0, 0, 2, 1);
    cfg_write(0, 1, 10, 1);
    cfg_write(0, 2, 0, 1);
    cfg_write(0, 4, 1, 1);
    prep_trig();
    do_arm();
    start_manual();
    repeat (4) tick();
    chk("pre_reset_glitch", 64'(o_glitch), 64'(exp_vec(4)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_glitch", 64'(o_glitch), 64'(0));
    chk("async_rst_state", 64'(o_state), 64'(0));
    chk("async_rst_done", 64'(o_done), 64'(0));
    chk("async_rst_cfg_err", 64'(o_cfg_err), 64'(0));
    model_clear();
    @(negedge sysclk);
    rst_n = 1'b1;
    tick();
    chk("after_rst_state", 64'(o_state), 64'(0));
    do_arm();
    start_manual();
    check_run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
